// File: rtl/common_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : common_pkg                                                 |
// | Brief   : Project-wide shared types (single-bit strobe encoding).    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package common_pkg;

    // Single-bit strobe/flag encoding used for grants, responses and flags
    typedef enum logic {
        SIG_LO = 1'b0,
        SIG_HI = 1'b1
    } onebit_sig_e;

endpackage : common_pkg
`default_nettype wire

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : core_pkg                                                   |
// | Brief   : Core-side types for the instruction/data memory arbiter.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package core_pkg;

    // Arbiter FSM: REQ_x holds a locked request, WAIT_x awaits the response
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } arb_state_e;

    // Which requester currently owns the shared memory port
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                           |
// | Brief   : Shares one memory port between instruction fetch and       |
// |           load/store. Data has priority, with a starvation limit     |
// |           for fetch. One transaction outstanding; flush drops a      |
// |           pending instruction response.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mem_port_arbiter
    import core_pkg::*;
    import common_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    // instruction fetch port
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    // load/store port
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    // shared memory port
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i
);

    localparam int                 c_CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    arb_state_e         r_state;
    logic [c_CNT_W-1:0] r_starve_cnt;
    onebit_sig_e        r_drop;

    logic        w_active;
    arb_owner_e  w_owner;
    onebit_sig_e w_i_gnt;
    onebit_sig_e w_d_gnt;
    onebit_sig_e w_i_rvalid;
    onebit_sig_e w_d_rvalid;

    // Pick the owner of the memory port: fresh arbitration in IDLE, locked owner in REQ_x
    always_comb begin
        w_active = 1'b0;
        w_owner  = OWN_D;
        case (r_state)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    w_active = 1'b1;
                    // Fetch wins when alone, or when data has hogged the port long enough
                    if (i_req_i && (!d_req_i || (r_starve_cnt == c_CNT_MAX))) begin
                        w_owner = OWN_I;
                    end
                end
            end
            REQ_I: begin
                w_active = 1'b1;
                w_owner  = OWN_I;
            end
            REQ_D: begin
                w_active = 1'b1;
                w_owner  = OWN_D;
            end
            default: begin
                w_active = 1'b0;
                w_owner  = OWN_D;
            end
        endcase
        if (reset_i) begin
            w_active = 1'b0;
        end
    end

    // Memory request mux, grant routing and response steering
    always_comb begin
        m_req_o   = w_active;
        m_we_o    = 1'b0;
        m_be_o    = 4'b0000;
        m_addr_o  = 32'h0;
        m_wdata_o = 32'h0;
        if (w_active) begin
            if (w_owner == OWN_I) begin
                m_be_o   = 4'b1111;
                m_addr_o = i_addr_i;
            end else begin
                m_we_o    = d_we_i;
                m_be_o    = d_be_i;
                m_addr_o  = d_addr_i;
                m_wdata_o = d_wdata_i;
            end
        end

        w_i_gnt = onebit_sig_e'(w_active && (w_owner == OWN_I) && m_gnt_i);
        w_d_gnt = onebit_sig_e'(w_active && (w_owner == OWN_D) && m_gnt_i);

        // A flush arriving together with the response also kills it, so a
        // flushed fetch never leaks into the pipeline
        w_i_rvalid = onebit_sig_e'(!reset_i && (r_state == WAIT_I) && m_rvalid_i &&
                                   (r_drop == SIG_LO) && !flush_i);
        w_d_rvalid = onebit_sig_e'(!reset_i && (r_state == WAIT_D) && m_rvalid_i);

        i_gnt_o    = w_i_gnt;
        d_gnt_o    = w_d_gnt;
        i_rvalid_o = w_i_rvalid;
        d_rvalid_o = w_d_rvalid;
        i_rdata_o  = (w_i_rvalid == SIG_HI) ? m_rdata_i : 32'h0;
        d_rdata_o  = (w_d_rvalid == SIG_HI) ? m_rdata_i : 32'h0;
    end

    // FSM, starvation counter and flush drop flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_drop       <= SIG_LO;
        end else begin
            // Starvation only accumulates while a fetch is actually waiting
            if (!i_req_i || (w_i_gnt == SIG_HI)) begin
                r_starve_cnt <= '0;
            end else if ((w_d_gnt == SIG_HI) && (r_starve_cnt != c_CNT_MAX)) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
            end

            if ((w_i_gnt == SIG_HI) && flush_i) begin
                r_drop <= SIG_HI;
            end else if (r_state == WAIT_I) begin
                if (m_rvalid_i) begin
                    r_drop <= SIG_LO;
                end else if (flush_i) begin
                    r_drop <= SIG_HI;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_active) begin
                        if (m_gnt_i) begin
                            r_state <= (w_owner == OWN_I) ? WAIT_I : WAIT_D;
                        end else begin
                            r_state <= (w_owner == OWN_I) ? REQ_I : REQ_D;
                        end
                    end
                end
                REQ_I: begin
                    // A grant in the flush cycle still commits the fetch
                    if (m_gnt_i) begin
                        r_state <= WAIT_I;
                    end else if (flush_i) begin
                        r_state <= IDLE;
                    end
                end
                REQ_D: begin
                    if (m_gnt_i) begin
                        r_state <= WAIT_D;
                    end
                end
                WAIT_I: begin
                    if (m_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_D: begin
                    if (m_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                        |
// | Brief   : Directed bench for mem_port_arbiter with a response        |
// |           scoreboard.                                                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o, i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        m_req_o, m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic        m_gnt_i, m_rvalid_i;
    logic [31:0] m_rdata_i;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush_i   (flush_i),
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_gnt_o   (i_gnt_o),
        .i_rvalid_o(i_rvalid_o),
        .i_rdata_o (i_rdata_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_be_i    (d_be_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_gnt_o   (d_gnt_o),
        .d_rvalid_o(d_rvalid_o),
        .d_rdata_o (d_rdata_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_be_o    (m_be_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_gnt_i   (m_gnt_i),
        .m_rvalid_i(m_rvalid_i),
        .m_rdata_i (m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        irv;
        logic        drv;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic push_exp(input logic irv, input logic drv, input logic [31:0] data);
        exp_t e;
        e.irv  = irv;
        e.drv  = drv;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s observed=response expected=empty_scoreboard_entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".i_rvalid"}, 32'(i_rvalid_o), 32'(e.irv));
            chk({tag, ".d_rvalid"}, 32'(d_rvalid_o), 32'(e.drv));
            chk({tag, ".i_rdata"},  i_rdata_o, e.irv ? e.data : 32'h0);
            chk({tag, ".d_rdata"},  d_rdata_o, e.drv ? e.data : 32'h0);
        end
    endtask

    task automatic clear_inputs();
        flush_i    = 1'b0;
        i_req_i    = 1'b0;
        i_addr_i   = 32'h0;
        d_req_i    = 1'b0;
        d_we_i     = 1'b0;
        d_be_i     = 4'h0;
        d_addr_i   = 32'h0;
        d_wdata_i  = 32'h0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'h0;
    endtask

    // Issue a granted data read from IDLE and complete it one cycle later
    task automatic data_read(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_be_i   = 4'hF;
        d_addr_i = addr;
        m_gnt_i  = 1'b1;
        sample();
        chk({tag, ".d_gnt"}, 32'(d_gnt_o), 32'd1);
        chk({tag, ".addr"},  m_addr_o, addr);
        push_exp(1'b0, 1'b1, rdata);
        tick();
        d_req_i    = 1'b0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = rdata;
        sample();
        check_resp(tag);
        tick();
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'h0;
    endtask

    initial begin
        int  exp_cnt;
        logic exp_i;

        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();

        // Reset: outputs held at zero even with live requests
        i_req_i  = 1'b1;
        i_addr_i = 32'h1234;
        d_req_i  = 1'b1;
        m_gnt_i  = 1'b1;
        sample();
        chk("rst.m_req", 32'(m_req_o), 32'd0);
        chk("rst.i_gnt", 32'(i_gnt_o), 32'd0);
        chk("rst.d_gnt", 32'(d_gnt_o), 32'd0);
        chk("rst.m_addr", m_addr_o, 32'h0);
        tick();
        clear_inputs();
        reset_i = 1'b0;
        tick();

        // Single instruction fetch, granted immediately
        i_req_i  = 1'b1;
        i_addr_i = 32'h8000_0004;
        m_gnt_i  = 1'b1;
        sample();
        chk("fetch.m_req",  32'(m_req_o), 32'd1);
        chk("fetch.m_addr", m_addr_o, 32'h8000_0004);
        chk("fetch.m_we",   32'(m_we_o), 32'd0);
        chk("fetch.m_be",   32'(m_be_o), 32'hF);
        chk("fetch.i_gnt",  32'(i_gnt_o), 32'd1);
        chk("fetch.d_gnt",  32'(d_gnt_o), 32'd0);
        push_exp(1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        i_req_i    = 1'b0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hDEAD_BEEF;
        sample();
        chk("fetch.wait_m_req", 32'(m_req_o), 32'd0);
        check_resp("fetch.resp");
        tick();
        m_rvalid_i = 1'b0;

        // Spurious response in IDLE is ignored
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h1234_5678;
        sample();
        chk("spur.i_rvalid", 32'(i_rvalid_o), 32'd0);
        chk("spur.d_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("spur.i_rdata",  i_rdata_o, 32'h0);
        chk("spur.d_rdata",  d_rdata_o, 32'h0);
        tick();
        m_rvalid_i = 1'b0;
        data_read("spur.after", 32'h40, 32'h55);

        // Locked store: fields stable while stalled, fetch arriving meanwhile
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_be_i    = 4'b0011;
        d_addr_i  = 32'h100;
        d_wdata_i = 32'hA5A5_A5A5;
        sample();
        chk("lock.c0.m_req", 32'(m_req_o), 32'd1);
        chk("lock.c0.m_we",  32'(m_we_o), 32'd1);
        chk("lock.c0.m_be",  32'(m_be_o), 32'h3);
        chk("lock.c0.d_gnt", 32'(d_gnt_o), 32'd0);
        tick();
        i_req_i  = 1'b1;
        i_addr_i = 32'h200;
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("lock.m_addr",  m_addr_o, 32'h100);
            chk("lock.m_be",    32'(m_be_o), 32'h3);
            chk("lock.m_wdata", m_wdata_o, 32'hA5A5_A5A5);
            chk("lock.i_gnt",   32'(i_gnt_o), 32'd0);
            chk("lock.d_gnt",   32'(d_gnt_o), 32'd0);
            tick();
        end
        m_gnt_i = 1'b1;
        sample();
        chk("lock.gnt.d_gnt",  32'(d_gnt_o), 32'd1);
        chk("lock.gnt.i_gnt",  32'(i_gnt_o), 32'd0);
        chk("lock.gnt.m_addr", m_addr_o, 32'h100);
        push_exp(1'b0, 1'b1, 32'hCAFE_0001);
        tick();
        clear_inputs();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hCAFE_0001;
        sample();
        check_resp("lock.resp");
        tick();
        m_rvalid_i = 1'b0;

        // Starvation: both requesting, memory always grants
        exp_cnt   = 0;
        i_req_i   = 1'b1;
        i_addr_i  = 32'h300;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_be_i    = 4'hF;
        d_addr_i  = 32'h400;
        m_gnt_i   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_i = (exp_cnt == 4);
            sample();
            chk("starve.i_gnt",  32'(i_gnt_o), 32'(exp_i));
            chk("starve.d_gnt",  32'(d_gnt_o), 32'(!exp_i));
            chk("starve.m_addr", m_addr_o, exp_i ? 32'h300 : 32'h400);
            push_exp(exp_i, !exp_i, 32'h1000 + 32'(k));
            exp_cnt = exp_i ? 0 : ((exp_cnt < 4) ? exp_cnt + 1 : 4);
            tick();
            m_rvalid_i = 1'b1;
            m_rdata_i  = 32'h1000 + 32'(k);
            sample();
            chk("starve.wait_i_gnt", 32'(i_gnt_o), 32'd0);
            check_resp("starve.resp");
            tick();
            m_rvalid_i = 1'b0;
        end
        clear_inputs();

        // Flush while waiting for a fetch response
        i_req_i  = 1'b1;
        i_addr_i = 32'h500;
        m_gnt_i  = 1'b1;
        sample();
        chk("flushw.i_gnt", 32'(i_gnt_o), 32'd1);
        tick();
        i_req_i = 1'b0;
        m_gnt_i = 1'b0;
        flush_i = 1'b1;
        sample();
        chk("flushw.pulse_i_rvalid", 32'(i_rvalid_o), 32'd0);
        tick();
        flush_i    = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hBAD0_BAD0;
        push_exp(1'b0, 1'b0, 32'h0);
        sample();
        check_resp("flushw.drop");
        tick();
        m_rvalid_i = 1'b0;
        data_read("flushw.next", 32'h600, 32'h66);

        // Flush while a fetch is stalled waiting for grant
        i_req_i  = 1'b1;
        i_addr_i = 32'h700;
        sample();
        chk("flushr.c0_i_gnt", 32'(i_gnt_o), 32'd0);
        tick();
        flush_i = 1'b1;
        sample();
        chk("flushr.m_req", 32'(m_req_o), 32'd1);
        chk("flushr.i_gnt", 32'(i_gnt_o), 32'd0);
        tick();
        clear_inputs();
        data_read("flushr.next", 32'h780, 32'h77);

        // Reset during WAIT_D abandons the transaction
        d_req_i  = 1'b1;
        d_be_i   = 4'hF;
        d_addr_i = 32'h800;
        m_gnt_i  = 1'b1;
        sample();
        chk("rstw.d_gnt", 32'(d_gnt_o), 32'd1);
        tick();
        clear_inputs();
        reset_i = 1'b1;
        sample();
        chk("rstw.m_req",    32'(m_req_o), 32'd0);
        chk("rstw.d_rvalid", 32'(d_rvalid_o), 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h88;
        sample();
        chk("rstw.late_d_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("rstw.late_d_rdata",  d_rdata_o, 32'h0);
        chk("rstw.late_i_rvalid", 32'(i_rvalid_o), 32'd0);
        chk("rstw.late_m_req",    32'(m_req_o), 32'd0);
        tick();
        m_rvalid_i = 1'b0;
        data_read("rstw.next", 32'h900, 32'h99);

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits.
REQ-002 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have flush_i  input  1  pipeline flush; suppresses a pending instruction response.
REQ-005 SHALL have i_req_i / i_addr_i[31:0]  input  instruction fetch request and word address.
REQ-006 SHALL have i_gnt_o / i_rvalid_o  output  1 each; i_rdata_o  output  32: instruction grant, response and data.
REQ-007 SHALL have d_req_i, d_we_i, d_be_i[3:0], d_addr_i[31:0], d_wdata_i[31:0]  input  load/store request fields.
REQ-008 SHALL have d_gnt_o / d_rvalid_o  output  1 each; d_rdata_o  output  32: data grant, response and data.
REQ-009 SHALL have m_req_o, m_we_o, m_be_o[3:0], m_addr_o[31:0], m_wdata_o[31:0]  output  shared memory port request.
REQ-010 SHALL have m_gnt_i, m_rvalid_i  input  1 each; m_rdata_i  input  32: memory grant, response and data.

Function
REQ-011 SHALL implement states IDLE, REQ_I, REQ_D, WAIT_I and WAIT_D, with at most one transaction outstanding.
REQ-012 In IDLE with any request, SHALL select a winner combinationally and drive m_* from it in the same cycle.
REQ-013 Arbitration SHALL favour data, except it SHALL favour instruction when starve_cnt == STARVE_LIMIT.
REQ-014 starve_cnt SHALL increment on each data grant while i_req_i=1, saturate at STARVE_LIMIT, and clear on an instruction grant or when i_req_i=0.
REQ-015 If m_gnt_i=1 in the selection cycle, state SHALL go to WAIT_x; otherwise it SHALL go to REQ_x and lock the winner.
REQ-016 In REQ_x, SHALL keep driving requester x only, with no re-arbitration, until m_gnt_i, then go to WAIT_x.
REQ-017 x_gnt_o SHALL equal m_gnt_i in the cycle m_req_o is driven for requester x, and SHALL be 0 otherwise.
REQ-018 Instruction requests SHALL drive m_we_o=0 and m_be_o=4'b1111; data requests SHALL pass d_we_i, d_be_i and d_wdata_i through.
REQ-019 In WAIT_x, m_req_o SHALL be 0; on m_rvalid_i, SHALL assert x_rvalid_o=1 combinationally with x_rdata_o=m_rdata_i and go to IDLE.
REQ-020 Re-arbitration SHALL take place in the IDLE cycle after the response, giving minimum 2 cycles per transaction.
REQ-021 flush_i=1 in REQ_I SHALL return state to IDLE with no grant, unless m_gnt_i=1 in that same cycle, in which case the transaction proceeds to WAIT_I.
REQ-022 flush_i=1 in WAIT_I, or in the cycle an instruction grant happens, SHALL set drop_flag.
REQ-023 When drop_flag=1, the instruction response SHALL be consumed, i_rvalid_o SHALL stay 0, and drop_flag SHALL clear.
REQ-024 flush_i SHALL NOT affect data transactions.
REQ-025 m_rvalid_i outside WAIT_x SHALL be ignored, with no output and no state change.
REQ-026 When both rvalid outputs are 0, i_rdata_o and d_rdata_o SHALL be 0.

Reset
REQ-027 reset_i SHALL force state=IDLE, starve_cnt=0 and drop_flag=0 immediately.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset during REQ_x or WAIT_x SHALL abandon the transaction, and its later m_rvalid_i SHALL be ignored per REQ-025.

Structure
REQ-030 The arb_state_e enum and the arb_owner_e enum {OWN_I, OWN_D} SHALL be placed in core_pkg.
REQ-031 1-bit strobes SHALL use onebit_sig_e from common_pkg.
REQ-032 SHALL be a single module with no sub-modules; the starve counter is inline, width $clog2(STARVE_LIMIT+1).

Verification
REQ-033 i_req_i=1 alone, i_addr_i=0x80000004, m_gnt_i=1, rvalid 1 cycle later with rdata 0xDEADBEEF -> i_gnt_o in cycle 0, i_rvalid_o=1 with i_rdata_o=0xDEADBEEF in cycle 1.
REQ-034 i_req_i and d_req_i both held, memory always grants -> sequence D,D,D,D,I,D,... (STARVE_LIMIT=4).
REQ-035 d_req_i store with be=4'b0011 and m_gnt_i low for 3 cycles while i_req_i rises -> data stays locked with fields stable, then d_gnt_o=1 and i_gnt_o=0.
REQ-036 flush_i pulsed in WAIT_I -> m_rvalid_i consumed, i_rvalid_o=0, next request accepted in the following IDLE cycle.
REQ-037 reset_i asserted in WAIT_D, then m_rvalid_i after release -> d_rvalid_o=0, state IDLE, all outputs 0.
REQ-038 Spurious m_rvalid_i in IDLE -> no rvalid output and no state change.
